// File: rtl/md_unit_if.sv
// md_unit_if: the EX-stage request, HI/LO write/read and status signals of the
// multiply/divide unit, grouped as one bundle.
// master = pipeline side (drives requests), slave = md_unit.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             we;
  logic             wsel;
  logic [WIDTH-1:0] wdata;
  logic             rsel;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic             md_stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, cancel, op, a, b, we, wsel, wdata, rsel,
    input  rdata, busy, md_stall, hi, lo
  );

  modport slave (
    input  start, cancel, op, a, b, we, wsel, wdata, rsel,
    output rdata, busy, md_stall, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO for the MIPS EX stage.
// mult/multu/div/divu run for MULT_CYCLES / DIV_CYCLES, then commit to HI/LO.
// mthi/mtlo writes go through the we/wsel/wdata port when idle.
// Optional build macro MD_MADD_EN enables madd/maddu/msub/msubu (op 1xx);
// without it those encodings are reserved and ignored.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  md_unit_if.slave      bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // The countdown counter is the state: zero means idle.
  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             op_valid;
  logic             accept;
  logic             wr_en;

  logic             a_sx;
  logic             b_sx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]   dvd_x;
  logic [WIDTH:0]   dvs_x;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

`ifdef MD_MADD_EN
  logic [2*WIDTH-1:0] macc;
  assign op_valid = 1'b1;
`else
  assign op_valid = ~bus.op[2];
`endif

  assign state  = (cnt_q == '0) ? IDLE : RUN;
  assign accept = bus.start & ~bus.cancel & (state == IDLE) & op_valid;
  assign wr_en  = bus.we & ~bus.cancel & (state == IDLE) & ~accept;

  // Datapath on latched operands: op[0] set means unsigned for every op class.
  // Extending both operands to 2*WIDTH makes the low 2*WIDTH product bits correct
  // for signed and unsigned alike. The divide runs one bit wider so that
  // most-negative / -1 yields +2^(WIDTH-1), which truncates to most-negative.
  always_comb begin
    a_sx  = ~op_q[0] & a_q[WIDTH-1];
    b_sx  = ~op_q[0] & b_q[WIDTH-1];
    prod  = {{WIDTH{a_sx}}, a_q} * {{WIDTH{b_sx}}, b_q};
    dvd_x = {a_sx, a_q};
    dvs_x = {b_sx, b_q};
    quo   = WIDTH'($signed(dvd_x) / $signed(dvs_x));
    rem   = WIDTH'($signed(dvd_x) % $signed(dvs_x));
`ifdef MD_MADD_EN
    macc  = op_q[1] ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif
  end

  // Next-state: accept / mthi-mtlo in IDLE, count down and commit in RUN.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_d = (bus.op[2:1] == 2'b01) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          op_d  = bus.op;
          a_d   = bus.a;
          b_d   = bus.b;
        end else if (wr_en) begin
          if (bus.wsel) lo_d = bus.wdata;
          else          hi_d = bus.wdata;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          case (op_q)
            3'b000, 3'b001: {hi_d, lo_d} = prod;
            3'b010, 3'b011: begin
              // Divide by zero leaves HI/LO untouched.
              if (b_q != '0) begin
                hi_d = rem;
                lo_d = quo;
              end
            end
`ifdef MD_MADD_EN
            default: {hi_d, lo_d} = macc;
`else
            default: ;
`endif
          endcase
        end
      end
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.md_stall = (state == RUN) | (bus.start & ~bus.cancel);
  assign bus.rdata    = bus.rsel ? lo_q : hi_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven directed vectors, hand-written corner sequences and
// randomized operations checked against an arithmetic reference model of HI/LO.
module tb_md_unit;

  localparam int W     = 32;
  localparam int MULTC = 5;
  localparam int DIVC  = 10;

  logic clk;
  logic reset;

  md_unit_if #(.WIDTH(W)) bus ();

  md_unit #(
    .WIDTH      (W),
    .MULT_CYCLES(MULTC),
    .DIV_CYCLES (DIVC)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference HI/LO state.
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input logic [2:0] op);
    return (op == 3'b010 || op == 3'b011) ? DIVC : MULTC;
  endfunction

  // Architectural effect of one completed operation, from the instruction definitions.
  function automatic void model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint   sa, sb, q, r;
    bit [63:0] p, hl;
    sa = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    p  = 64'(sa * sb);
    hl = {m_hi, m_lo};
    case (op)
      3'b000, 3'b001: hl = p;
      3'b010, 3'b011: begin
        if (b != 0) begin
          q  = sa / sb;
          r  = sa % sb;
          hl = {r[31:0], q[31:0]};
        end
      end
      3'b100, 3'b101: hl = hl + p;
      default:        hl = hl - p;
    endcase
    m_hi = hl[63:32];
    m_lo = hl[31:0];
  endfunction

  task automatic idle_inputs();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = 3'b000;
    bus.a      = '0;
    bus.b      = '0;
    bus.we     = 1'b0;
    bus.wsel   = 1'b0;
    bus.wdata  = '0;
    bus.rsel   = 1'b0;
  endtask

  // Issue one op from the idle state and count busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    #1;
    check("md_stall_in_start_cycle", bus.md_stall, 1'b1);
    step();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      step();
    end
  endtask

  task automatic do_write(input logic sel, input logic [W-1:0] data);
    bus.we    = 1'b1;
    bus.wsel  = sel;
    bus.wdata = data;
    step();
    bus.we = 1'b0;
    if (sel) m_lo = data;
    else     m_hi = data;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic [W-1:0] old_hi, old_lo;

    vecs[0] = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MULTC};
    vecs[1] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MULTC};
    vecs[2] = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIVC};
    vecs[3] = '{3'b011, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIVC};
    vecs[4] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIVC};
    vecs[5] = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, DIVC};
    vecs[6] = '{3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MULTC};
    vecs[7] = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIVC};

    idle_inputs();
    reset = 1'b1;
    m_hi  = '0;
    m_lo  = '0;
    repeat (2) step();
    check("reset_hi", bus.hi, '0);
    check("reset_lo", bus.lo, '0);
    check("reset_busy", bus.busy, 1'b0);
    reset = 1'b0;
    step();

    // Directed vectors from the table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      model_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_cycles", i), n, vecs[i].cyc);
      check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
    end

    // Cancelled start: never accepted.
    old_hi = bus.hi;
    old_lo = bus.lo;
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 3'b000; bus.a = 32'd9; bus.b = 32'd9;
    #1;
    check("cancel_md_stall", bus.md_stall, 1'b0);
    step();
    idle_inputs();
    check("cancel_busy", bus.busy, 1'b0);
    step();
    check("cancel_hi", bus.hi, old_hi);
    check("cancel_lo", bus.lo, old_lo);

    // Idle mtlo/mthi writes and combinational read mux.
    do_write(1'b1, 32'h0000_1234);
    check("write_lo", bus.lo, 32'h0000_1234);
    bus.rsel = 1'b1; #1;
    check("rdata_lo", bus.rdata, 32'h0000_1234);
    do_write(1'b0, 32'h0000_0077);
    bus.rsel = 1'b0; #1;
    check("rdata_hi", bus.rdata, 32'h0000_0077);

    // Write while busy is dropped; old HI shown during the run.
    bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'd2; bus.b = 32'd2;
    step();
    bus.start = 1'b0;
    bus.we = 1'b1; bus.wsel = 1'b0; bus.wdata = 32'h5555_5555;
    step();
    bus.we = 1'b0;
    check("busy_write_dropped", bus.hi, 32'h0000_0077);
    check("md_stall_while_busy", bus.md_stall, 1'b1);
    n = 0;
    while (bus.busy && n < 200) begin n++; step(); end
    check("busy_write_cycles", n, MULTC - 1);
    model_op(3'b001, 32'd2, 32'd2);
    check("busy_write_lo", bus.lo, 32'd4);

    // Start while busy is ignored; first result intact.
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd4;
    step();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      if (n == 2) begin
        bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd7;
      end
      step();
      bus.start = 1'b0;
    end
    model_op(3'b000, 32'd3, 32'd4);
    check("restart_cycles", n, MULTC);
    check("restart_hi", bus.hi, 32'd0);
    check("restart_lo", bus.lo, 32'd12);

    // Reset three cycles into a divide.
    do_write(1'b0, 32'h0000_AAAA);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd7;
    step();
    bus.start = 1'b0;
    step();
    step();
    check("pre_reset_busy", bus.busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("midop_reset_busy", bus.busy, 1'b0);
    check("midop_reset_hi", bus.hi, '0);
    check("midop_reset_lo", bus.lo, '0);
    #1;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.busy) n++;
    end
    check("post_reset_no_busy", n, 0);
    check("post_reset_hi", bus.hi, '0);
    check("post_reset_lo", bus.lo, '0);

    // Start and we together: only the operation happens.
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd5; bus.b = 32'd6;
    bus.we = 1'b1; bus.wsel = 1'b1; bus.wdata = 32'h0000_DEAD;
    step();
    idle_inputs();
    check("start_we_lo_kept", bus.lo, 32'd0);
    n = 0;
    while (bus.busy && n < 200) begin n++; step(); end
    model_op(3'b000, 32'd5, 32'd6);
    check("start_we_cycles", n, MULTC);
    check("start_we_lo", bus.lo, 32'd30);

`ifdef MD_MADD_EN
    do_write(1'b0, 32'h0000_0000);
    do_write(1'b1, 32'hFFFF_FFFF);
    run_op(3'b100, 32'd1, 32'd1, n);
    model_op(3'b100, 32'd1, 32'd1);
    check("madd_cycles", n, MULTC);
    check("madd_hi", bus.hi, 32'h0000_0001);
    check("madd_lo", bus.lo, 32'h0000_0000);
    do_write(1'b0, 32'h0000_0000);
    do_write(1'b1, 32'h0000_0000);
    run_op(3'b111, 32'd1, 32'd1, n);
    model_op(3'b111, 32'd1, 32'd1);
    check("msubu_hi", bus.hi, 32'hFFFF_FFFF);
    check("msubu_lo", bus.lo, 32'hFFFF_FFFF);
`else
    old_hi = bus.hi;
    old_lo = bus.lo;
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'd1; bus.b = 32'd1;
    #1;
    check("reserved_md_stall", bus.md_stall, 1'b1);
    step();
    bus.start = 1'b0;
    check("reserved_busy", bus.busy, 1'b0);
    repeat (MULTC + 1) step();
    check("reserved_hi", bus.hi, old_hi);
    check("reserved_lo", bus.lo, old_lo);
`endif

    // Randomized operations, writes and cancelled starts.
    for (int i = 0; i < 60; i++) begin
      n = int'($urandom_range(0, 99));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 3))
        0: rb = rb % 32'd17;
        1: begin ra = ra % 32'd1000; rb = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0; end
        2: ra = 32'h8000_0000;
        default: ;
      endcase
`ifdef MD_MADD_EN
      rop = 3'($urandom_range(0, 7));
`else
      rop = 3'($urandom_range(0, 3));
`endif
      if (n < 15) begin
        do_write(1'($urandom_range(0, 1)), ra);
        check($sformatf("rnd%0d_w_hi", i), bus.hi, m_hi);
        check($sformatf("rnd%0d_w_lo", i), bus.lo, m_lo);
      end else if (n < 30) begin
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = rop; bus.a = ra; bus.b = rb;
        step();
        idle_inputs();
        check($sformatf("rnd%0d_cancel_busy", i), bus.busy, 1'b0);
        check($sformatf("rnd%0d_cancel_lo", i), bus.lo, m_lo);
      end else begin
        run_op(rop, ra, rb, n);
        model_op(rop, ra, rb);
        check($sformatf("rnd%0d_cycles", i), n, lat(rop));
        check($sformatf("rnd%0d_hi", i), bus.hi, m_hi);
        check($sformatf("rnd%0d_lo", i), bus.lo, m_lo);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit in the EX stage of the pipelined MIPS core.
- Executes mult/multu/div/divu with a configurable multi-cycle latency and owns the HI/LO registers.
- Services mthi/mtlo writes and mfhi/mflo reads.
- Exports a busy/stall indication to the hazard unit. Accepts a cancel so that an instruction killed by an exception or interrupt never starts.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- MULT_CYCLES, 5, busy cycles for multiply-class ops; must be >= 1.
- DIV_CYCLES, 10, busy cycles for divide-class ops; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  a multiply/divide instruction is in EX this cycle.
- cancel  input  1  EX instruction is being flushed; suppresses start and we.
- op  input  3  000 mult, 001 multu, 010 div, 011 divu; 1xx reserved (see Optional Feature).
- a  input  WIDTH  rs operand.
- b  input  WIDTH  rt operand.
- we  input  1  mthi/mtlo write request.
- wsel  input  1  write target: 0 = HI, 1 = LO.
- wdata  input  WIDTH  mthi/mtlo data.
- rsel  input  1  read select: 0 = HI, 1 = LO.
- rdata  output  WIDTH  selected HI/LO value, combinational from the registers.
- busy  output  1  an operation is in progress.
- md_stall  output  1  busy | (start & ~cancel); consumed by the hazard unit.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, any time including mid-operation):
  - hi = 0, lo = 0, busy = 0, cycle counter = 0.
  - Latched operands and latched op cleared; any in-flight result is discarded.
- Accept rule: at a rising edge with start=1, cancel=0, busy=0 and a valid op, the unit latches a, b and op. The counter loads MULT_CYCLES for op 00x or DIV_CYCLES for op 01x.
- Start is ignored in these cases:
  - busy=1 (the hazard unit guarantees this does not happen in correct use);
  - cancel=1;
  - op reserved (1xx without MADD_EN).
- States: IDLE (cnt = 0) and RUN (cnt != 0); busy = (cnt != 0).
  - In RUN, cnt decrements by 1 each edge.
  - At the edge where cnt goes 1 -> 0, HI/LO commit and the state returns to IDLE.
  - Accept at edge t gives busy=1 for cycles t+1 .. t+N. New HI/LO are visible after edge t+N, with busy=0 in the same cycle.
- Arithmetic, computed from the latched operands:
  - mult/multu: full 2*WIDTH product, signed or unsigned; HI = upper half, LO = lower half.
  - div/divu: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - Divide by zero: HI and LO unchanged; busy still runs for the full DIV_CYCLES.
  - Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- Write port: at an edge with we=1, cancel=0, busy=0 and no accepted start, the register selected by wsel takes wdata.
  - we while busy is ignored.
  - Start and we in the same cycle: start wins and the write is dropped.
- Reads: rdata = rsel ? lo : hi, combinational. During RUN the old values are shown; the hazard unit stalls mfhi/mflo while md_stall=1.
- md_stall is combinational and asserts in the start cycle itself, so the following instruction stalls with no bubble gap.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: op 100 madd, 101 maddu, 110 msub, 111 msubu are valid.
  - Latency is MULT_CYCLES.
  - At commit, {HI,LO} = {HI,LO} +/- product, using HI/LO as they stand at the commit edge.
  - Wrap-around is modulo 2^(2*WIDTH).
- Not defined: op 1xx is reserved. Start with a reserved op is ignored: busy stays 0, md_stall = start only, and HI/LO are unchanged.

Test Plan:
- Reset, then mult with a=0xFFFFFFFF, b=2 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 -> hi/lo keep their prior values and busy still lasts 10 cycles.
- Signed div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start with cancel=1 -> busy never rises and hi/lo unchanged. Start while busy -> ignored, first result intact. we=1, wsel=1, wdata=0x1234 while idle -> lo=0x1234 next edge and rdata with rsel=1 shows 0x1234. The same write while busy -> dropped.
- Assert reset 3 cycles into a div -> busy=0, hi=lo=0 immediately, no later commit. Then start and we in the same cycle -> only the operation occurs.
- With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, madd 1*1 -> hi=1, lo=0. msubu 1*1 from 0 -> hi=lo=0xFFFFFFFF. Without the macro, op=100 -> ignored.
